// File: rtl/spi_slave.sv
// SPI mode-0 responder with a small register file written (and optionally read back) over two-byte frames.
// Optional read-back path enabled by defining SPI_SLV_READBACK_EN.
module spi_slave #(
  parameter int NUM_BITS = 8,
  parameter int DEPTH    = 8
) (
  input  logic                     pclk_i,
  input  logic                     prst_n_i,
  input  logic                     sclk_i,
  input  logic                     cs_n_i,
  input  logic                     mosi_i,
  output logic                     miso_o,
  output logic                     miso_oe_o,
  output logic                     wr_valid_o,
  output logic [NUM_BITS-2:0]      wr_addr_o,
  output logic [NUM_BITS-1:0]      wr_data_o,
  output logic                     frame_err_o,
  input  logic [$clog2(DEPTH)-1:0] rd_addr_i,
  output logic [NUM_BITS-1:0]      rd_data_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(NUM_BITS) + 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(NUM_BITS - 1);

  typedef enum logic [1:0] {IDLE, ADDR, DATA, DONE} state_t;

  state_t state, state_nxt;

  logic sclk_s1, sclk_s2, sclk_s3;
  logic cs_s1, cs_s2, cs_s3;
  logic mosi_s1, mosi_s2;
  logic sclk_rise, sclk_fall, cs_fall;

  logic [CW-1:0]       bit_cnt;
  logic [NUM_BITS-1:0] rx_shift;
  logic [NUM_BITS-1:0] rx_next;
  logic [NUM_BITS-2:0] addr_q;
  logic [NUM_BITS-1:0] regs [DEPTH];

  logic bit_clr, bit_inc, latch_addr, commit, err;
  logic is_write;

  always_ff @(posedge pclk_i or negedge prst_n_i) begin
    if (!prst_n_i) begin
      sclk_s1 <= 1'b0;
      sclk_s2 <= 1'b0;
      sclk_s3 <= 1'b0;
      cs_s1   <= 1'b0;
      cs_s2   <= 1'b0;
      cs_s3   <= 1'b0;
      mosi_s1 <= 1'b0;
      mosi_s2 <= 1'b0;
    end else begin
      sclk_s1 <= sclk_i;
      sclk_s2 <= sclk_s1;
      sclk_s3 <= sclk_s2;
      cs_s1   <= cs_n_i;
      cs_s2   <= cs_s1;
      cs_s3   <= cs_s2;
      mosi_s1 <= mosi_i;
      mosi_s2 <= mosi_s1;
    end
  end

  // mosi passes through the same two stages as sclk, so mosi_s2 is aligned with the detected edge
  assign sclk_rise = sclk_s2 & ~sclk_s3;
  assign sclk_fall = ~sclk_s2 & sclk_s3;
  assign cs_fall   = ~cs_s2 & cs_s3;
  assign rx_next   = {rx_shift[NUM_BITS-2:0], mosi_s2};

  always_ff @(posedge pclk_i or negedge prst_n_i) begin
    if (!prst_n_i) state <= IDLE;
    else           state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    bit_clr    = 1'b0;
    bit_inc    = 1'b0;
    latch_addr = 1'b0;
    commit     = 1'b0;
    err        = 1'b0;
    unique case (state)
      IDLE: begin
        if (cs_fall) begin
          state_nxt = ADDR;
          bit_clr   = 1'b1;
        end
      end
      ADDR: begin
        if (cs_s2) begin
          state_nxt = IDLE;
          err       = (bit_cnt != '0);
        end else if (sclk_rise) begin
          if (bit_cnt == LAST_BIT) begin
            state_nxt  = DATA;
            latch_addr = 1'b1;
            bit_clr    = 1'b1;
          end else begin
            bit_inc = 1'b1;
          end
        end
      end
      DATA: begin
        if (cs_s2) begin
          state_nxt = IDLE;
          err       = 1'b1;
        end else if (sclk_rise) begin
          if (bit_cnt == LAST_BIT) begin
            state_nxt = DONE;
            commit    = 1'b1;
          end else begin
            bit_inc = 1'b1;
          end
        end
      end
      DONE: begin
        if (cs_s2) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge pclk_i or negedge prst_n_i) begin
    if (!prst_n_i) begin
      bit_cnt     <= '0;
      rx_shift    <= '0;
      addr_q      <= '0;
      wr_valid_o  <= 1'b0;
      wr_addr_o   <= '0;
      wr_data_o   <= '0;
      frame_err_o <= 1'b0;
      for (int unsigned i = 0; i < DEPTH; i++) regs[i] <= '0;
    end else begin
      if (bit_clr)      bit_cnt <= '0;
      else if (bit_inc) bit_cnt <= bit_cnt + 1'b1;

      if (cs_fall && state == IDLE)
        rx_shift <= '0;
      else if (sclk_rise && (state == ADDR || state == DATA))
        rx_shift <= rx_next;

      if (latch_addr) addr_q <= rx_next[NUM_BITS-2:0];

      wr_valid_o  <= commit & is_write;
      frame_err_o <= err;
      if (commit && is_write) begin
        regs[addr_q[AW-1:0]] <= rx_next;
        wr_addr_o            <= addr_q;
        wr_data_o            <= rx_next;
      end
    end
  end

  assign rd_data_o = regs[rd_addr_i];

`ifdef SPI_SLV_READBACK_EN
  logic                rd_act;
  logic [NUM_BITS-1:0] tx_shift;

  assign is_write = ~rd_act;

  always_ff @(posedge pclk_i or negedge prst_n_i) begin
    if (!prst_n_i) begin
      rd_act    <= 1'b0;
      tx_shift  <= '0;
      miso_o    <= 1'b0;
      miso_oe_o <= 1'b0;
    end else begin
      miso_oe_o <= ~cs_s2;
      if (latch_addr) begin
        rd_act   <= rx_next[NUM_BITS-1];
        tx_shift <= regs[rx_next[AW-1:0]];
      end else if (state != DATA) begin
        rd_act <= 1'b0;
      end
      if (state == DATA && rd_act && sclk_fall) begin
        miso_o   <= tx_shift[NUM_BITS-1];
        tx_shift <= {tx_shift[NUM_BITS-2:0], 1'b0};
      end else if (state != DATA || !rd_act) begin
        miso_o <= 1'b0;
      end
    end
  end
`else
  assign is_write  = 1'b1;
  assign miso_o    = 1'b0;
  assign miso_oe_o = 1'b0;
`endif

endmodule

// File: doc/spi_slave.md
SPI_SLAVE -- requirements
Module: spi_slave

Interface
REQ-001 SHALL have parameter NUM_BITS, default 8, SPI frame byte width.
REQ-002 SHALL have parameter DEPTH, default 8, number of NUM_BITS-wide registers (power of 2, ≤ 2^(NUM_BITS-1)).
REQ-003 SHALL have port pclk_i, input, 1, sole clock; all logic on rising edge.
REQ-004 SHALL have port prst_n_i, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port sclk_i, input, 1, SPI serial clock from the controller, asynchronous to pclk_i.
REQ-006 SHALL have port cs_n_i, input, 1, active-low chip select.
REQ-007 SHALL have port mosi_i, input, 1, controller-out serial data.
REQ-008 SHALL have port miso_o, output, 1, responder-out serial data.
REQ-009 SHALL have port miso_oe_o, output, 1, miso drive enable; high only while selected.
REQ-010 SHALL have port wr_valid_o, output, 1, one-pclk pulse per committed write.
REQ-011 SHALL have port wr_addr_o, output, NUM_BITS-1, address of the committed write.
REQ-012 SHALL have port wr_data_o, output, NUM_BITS, data of the committed write.
REQ-013 SHALL have port frame_err_o, output, 1, one-pclk pulse on an aborted frame.
REQ-014 SHALL have port rd_addr_i, input, log2(DEPTH), local register read index.
REQ-015 SHALL have port rd_data_o, output, NUM_BITS, combinational register file read of rd_addr_i.

Function
REQ-016 SHALL synchronise sclk_i, cs_n_i and mosi_i through 2-flop synchronisers and detect sclk edges from synchronised values; sclk frequency ≤ pclk/4.
REQ-017 SHALL use SPI mode 0: sample mosi on sclk rise, update miso on sclk fall, MSB first.
REQ-018 SHALL define a frame as byte 1 = {rw, addr[NUM_BITS-2:0]} (rw=1 read), byte 2 = data.
REQ-019 SHALL implement states IDLE, ADDR, DATA, DONE.
REQ-020 SHALL go IDLE->ADDR on synchronised cs_n falling edge, with bit counter cleared.
REQ-021 SHALL go ADDR->DATA on the NUM_BITS-th sampled rise, latching rw and addr.
REQ-022 SHALL, in DATA on the NUM_BITS-th sampled rise: for writes, store data to reg[addr mod DEPTH] and pulse wr_valid_o with wr_addr_o/wr_data_o; then go to DONE.
REQ-023 SHALL commit within 4 pclk cycles of the raw sclk rising edge.
REQ-024 SHALL ignore further sclk edges in DONE; DONE->IDLE on cs_n high.
REQ-025 SHALL, on cs_n high in ADDR or DATA, pulse frame_err_o for 1 cycle, commit nothing, and go to IDLE; cs_n high in ADDR with zero bits received SHALL return to IDLE with no error.
REQ-026 SHALL, for reads, load reg[addr mod DEPTH] into the transmit shifter at end of ADDR and drive its MSB on the following sclk fall, then shift one bit per fall.
REQ-027 SHALL drive miso_o = 0 whenever not shifting read data; miso_oe_o = ~synchronised cs_n.
REQ-028 SHALL truncate addresses to log2(DEPTH) bits when indexing (wrap-around); wr_addr_o carries the full NUM_BITS-1 address.

Reset
REQ-029 SHALL, on prst_n_i low, immediately clear the state to IDLE and clear all counters, shifters, synchronisers, registers, miso_o, miso_oe_o, wr_valid_o, wr_addr_o, wr_data_o and frame_err_o to 0.
REQ-030 SHALL, on reset asserted mid-frame, discard the frame without a frame_err_o pulse; after release, the next frame starts on a fresh cs_n fall.

Configuration
REQ-031 SHALL, with SPI_SLV_READBACK_EN defined, support reads per REQ-026.
REQ-032 SHALL, without SPI_SLV_READBACK_EN, treat every frame as a write (rw bit ignored, addr still bits NUM_BITS-2:0) and tie miso_o and miso_oe_o to 0.

Verification
REQ-033 SHALL cover: write frame 0x03,0x56 -> wr_valid_o pulse, wr_addr_o=0x03, wr_data_o=0x56; rd_addr_i=3 gives rd_data_o=0x56.
REQ-034 SHALL cover: with macro, read frame 0x83 after REQ-033 -> miso_o bits 0,1,0,1,0,1,1,0 sampled on byte-2 rises; no wr_valid_o.
REQ-035 SHALL cover: cs_n raised after 5 data bits of frame 0x04,0xAA -> frame_err_o pulse, reg[4] unchanged.
REQ-036 SHALL cover: write 0x0B,0x77 with DEPTH=8 -> reg[3]=0x77, wr_addr_o=0x0B.
REQ-037 SHALL cover: prst_n_i low during ADDR -> all outputs 0; the next full frame 0x01,0x11 commits normally.
REQ-038 SHALL cover: without macro, frame 0x85,0x22 -> write of 0x22 to reg[5]; miso_o stays 0.
